// File: rtl/pmod_ssd_mux_axi_pkg.sv
// ============================================================================
// Module  : pmod_ssd_mux_axi_pkg
// Brief   : Register map, handshake states and decode helpers for the SSD mux.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pmod_ssd_mux_axi_pkg;

    localparam logic [2:0] C_REG_CTRL   = 3'd0;
    localparam logic [2:0] C_REG_DATA   = 3'd1;
    localparam logic [2:0] C_REG_DP     = 3'd2;
    localparam logic [2:0] C_REG_SCAN   = 3'd3;
    localparam logic [2:0] C_REG_BRIGHT = 3'd4;
    localparam logic [2:0] C_REG_RAWSEG = 3'd5;
    localparam logic [2:0] C_REG_STATUS = 3'd6;

    localparam int C_CTRL_EN    = 0;
    localparam int C_CTRL_BLINK = 1;
    localparam int C_CTRL_RAW   = 2;

    localparam logic [1:0] C_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_ACCEPT = 2'd1,
        WR_RESP   = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_ACCEPT = 2'd1,
        RD_DATA   = 2'd2
    } rd_state_t;

    // Segment order {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        logic [31:0] v;
        v = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) v[8*b +: 8] = wdata[8*b +: 8];
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pmod_ssd_mux_axi_scan.sv
// ============================================================================
// Module  : pmod_ssd_mux_axi_scan
// Brief   : Digit scan prescaler, PWM dimming, blink and registered decode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pmod_ssd_mux_axi_scan
    import pmod_ssd_mux_axi_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int BLINK_TICKS    = 250,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  blink_en,
    input  logic                  raw_mode,
    input  logic [31:0]           data,
    input  logic [7:0]            dp_mask,
    input  logic [15:0]           scan_div,
    input  logic [3:0]            bright,
    input  logic [31:0]           rawseg,
    input  logic                  restart,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] dig,
    output logic [2:0]            digit_idx,
    output logic                  blink_phase
);

    localparam int   BW        = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic C_SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic C_DIG_INV = (DIG_ACTIVE_LOW != 0);

    logic [15:0]           r_presc;
    logic [2:0]            r_idx;
    logic [3:0]            r_pwm;
    logic [BW-1:0]         r_bcnt;
    logic                  r_phase;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_dig;

    logic [15:0]           w_div_last;
    logic                  w_tick;
    logic [6:0]            w_seg;
    logic [6:0]            w_raw;
    logic                  w_lit;

    // SCAN_DIV of 0 behaves as 1: terminal count is 0 in both cases.
    assign w_div_last = (scan_div == 16'd0) ? 16'd0 : scan_div - 16'd1;
    assign w_tick     = !restart && (r_presc >= w_div_last);

    assign w_raw = r_idx[2] ? 7'd0 : rawseg[{r_idx[1:0], 3'b000} +: 7];
    assign w_seg = raw_mode ? w_raw : hex_to_seg(data[{r_idx, 2'b00} +: 4]);
    assign w_lit = en && (r_pwm <= bright) && !(blink_en && r_phase);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_pwm   <= '0;
            r_bcnt  <= '0;
            r_phase <= 1'b0;
            r_seg   <= {7{C_SEG_INV}};
            r_dp    <= C_SEG_INV;
            r_dig   <= {NUM_DIGITS{C_DIG_INV}};
        end else begin
            r_pwm <= r_pwm + 4'd1;
            if (restart || w_tick) r_presc <= '0;
            else                   r_presc <= r_presc + 16'd1;
            if (w_tick) begin
                r_idx <= (r_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
                if (r_bcnt == BW'(BLINK_TICKS - 1)) begin
                    r_bcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_bcnt <= r_bcnt + BW'(1);
                end
            end
            r_seg <= (w_lit ? w_seg : 7'd0) ^ {7{C_SEG_INV}};
            r_dp  <= (w_lit & dp_mask[r_idx]) ^ C_SEG_INV;
            r_dig <= (w_lit ? (NUM_DIGITS'(1) << r_idx) : '0) ^ {NUM_DIGITS{C_DIG_INV}};
        end
    end

    assign seg         = r_seg;
    assign dp          = r_dp;
    assign dig         = r_dig;
    assign digit_idx   = r_idx;
    assign blink_phase = r_phase;

endmodule

`default_nettype wire

// File: rtl/pmod_ssd_mux_axi.sv
// ============================================================================
// Module  : pmod_ssd_mux_axi
// Brief   : AXI4-Lite register slave for an N-digit multiplexed 7-seg display.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pmod_ssd_mux_axi
    import pmod_ssd_mux_axi_pkg::*;
#(
    parameter int          NUM_DIGITS     = 4,
    parameter logic [15:0] SCAN_DIV_RST   = 16'd50000,
    parameter int          BLINK_TICKS    = 250,
    parameter int          SEG_ACTIVE_LOW = 0,
    parameter int          DIG_ACTIVE_LOW = 0
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [4:0]            S_AXI_AWADDR,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [4:0]            S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] dig
);

    wr_state_t             r_wr_state, w_wr_next;
    rd_state_t             r_rd_state, w_rd_next;
    logic [2:0]            r_ctrl;
    logic [31:0]           r_data;
    logic [NUM_DIGITS-1:0] r_dp;
    logic [15:0]           r_scan_div;
    logic [3:0]            r_bright;
    logic [31:0]           r_rawseg;
    logic [31:0]           r_rdata;

    logic [2:0]            w_idx;
    logic                  w_phase;
    logic [2:0]            w_wr_sel;
    logic [31:0]           w_wr_val;
    logic                  w_wr_en;
    logic                  w_restart;
    logic                  w_unused;

    function automatic logic [31:0] reg_view(input logic [2:0] sel);
        logic [31:0] v;
        case (sel)
            C_REG_CTRL:   v = {29'd0, r_ctrl};
            C_REG_DATA:   v = r_data;
            C_REG_DP:     v = 32'(r_dp);
            C_REG_SCAN:   v = {16'd0, r_scan_div};
            C_REG_BRIGHT: v = {28'd0, r_bright};
            C_REG_RAWSEG: v = r_rawseg;
            C_REG_STATUS: v = {23'd0, w_phase, 5'd0, w_idx};
            default:      v = '0;
        endcase
        return v;
    endfunction

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_state <= WR_IDLE;
            r_rd_state <= RD_IDLE;
        end else begin
            r_wr_state <= w_wr_next;
            r_rd_state <= w_rd_next;
        end
    end

    // Ready is a registered one-cycle pulse; the master holds VALID through it.
    always_comb begin
        w_wr_next     = r_wr_state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (r_wr_state)
            WR_IDLE:   if (S_AXI_AWVALID && S_AXI_WVALID) w_wr_next = WR_ACCEPT;
            WR_ACCEPT: begin
                S_AXI_AWREADY = 1'b1;
                S_AXI_WREADY  = 1'b1;
                w_wr_next     = WR_RESP;
            end
            WR_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) w_wr_next = WR_IDLE;
            end
            default:   w_wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        w_rd_next     = r_rd_state;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        case (r_rd_state)
            RD_IDLE:   if (S_AXI_ARVALID) w_rd_next = RD_ACCEPT;
            RD_ACCEPT: begin
                S_AXI_ARREADY = 1'b1;
                w_rd_next     = RD_DATA;
            end
            RD_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) w_rd_next = RD_IDLE;
            end
            default:   w_rd_next = RD_IDLE;
        endcase
    end

    assign w_wr_sel  = S_AXI_AWADDR[4:2];
    assign w_wr_en   = (r_wr_state == WR_ACCEPT) && S_AXI_AWVALID && S_AXI_WVALID;
    assign w_wr_val  = apply_wstrb(reg_view(w_wr_sel), S_AXI_WDATA, S_AXI_WSTRB);
    assign w_restart = w_wr_en && (w_wr_sel == C_REG_SCAN);
    assign w_unused  = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_ctrl     <= '0;
            r_data     <= '0;
            r_dp       <= '0;
            r_scan_div <= SCAN_DIV_RST;
            r_bright   <= 4'hF;
            r_rawseg   <= '0;
        end else if (w_wr_en) begin
            case (w_wr_sel)
                C_REG_CTRL:   r_ctrl     <= w_wr_val[2:0];
                C_REG_DATA:   r_data     <= w_wr_val;
                C_REG_DP:     r_dp       <= w_wr_val[NUM_DIGITS-1:0];
                C_REG_SCAN:   r_scan_div <= w_wr_val[15:0];
                C_REG_BRIGHT: r_bright   <= w_wr_val[3:0];
                C_REG_RAWSEG: r_rawseg   <= w_wr_val;
                default:      ;
            endcase
        end
    end

    // Captured on the same edge a write lands, so a concurrent read sees the old value.
    always_ff @(posedge ACLK) begin
        if (ARESET)                      r_rdata <= '0;
        else if (r_rd_state == RD_ACCEPT) r_rdata <= reg_view(S_AXI_ARADDR[4:2]);
    end

    assign S_AXI_RDATA = r_rdata;
    assign S_AXI_BRESP = C_RESP_OKAY;
    assign S_AXI_RRESP = C_RESP_OKAY;

    pmod_ssd_mux_axi_scan #(
        .NUM_DIGITS     (NUM_DIGITS),
        .BLINK_TICKS    (BLINK_TICKS),
        .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW),
        .DIG_ACTIVE_LOW (DIG_ACTIVE_LOW)
    ) u_scan (
        .clk         (ACLK),
        .rst         (ARESET),
        .en          (r_ctrl[C_CTRL_EN]),
        .blink_en    (r_ctrl[C_CTRL_BLINK]),
        .raw_mode    (r_ctrl[C_CTRL_RAW]),
        .data        (r_data),
        .dp_mask     (8'(r_dp)),
        .scan_div    (r_scan_div),
        .bright      (r_bright),
        .rawseg      (r_rawseg),
        .restart     (w_restart),
        .seg         (seg),
        .dp          (dp),
        .dig         (dig),
        .digit_idx   (w_idx),
        .blink_phase (w_phase)
    );

endmodule

`default_nettype wire
